// File: rtl/mont_seq_pkg.sv
// Shared types for the Montgomery multiplier sequencer: mode encodings and FSM states.
package mont_seq_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_MUL       = 2'd0,
        MODE_TO_MONT   = 2'd1,
        MODE_FROM_MONT = 2'd2,
        MODE_RSVD      = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RUN    = 3'd2,
        REDUCE = 3'd3,
        DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/mont_seq_if.sv
// Request/response bundle between the point-arithmetic controller and mont_seq.
interface mont_seq_if #(parameter int unsigned WID = 256);

    logic           start;
    logic           ready;
    logic [1:0]     mode;
    logic [WID-1:0] a;
    logic [WID-1:0] b;
    logic [WID-1:0] r2;
    logic [WID-1:0] m;
    logic [WID-1:0] res;
    logic           res_vld;
    logic           res_ack;
    logic           err;

    modport master (
        output start, mode, a, b, r2, m, res_ack,
        input  ready, res, res_vld, err
    );

    modport slave (
        input  start, mode, a, b, r2, m, res_ack,
        output ready, res, res_vld, err
    );

endinterface

// File: rtl/mont_fred.sv
// Final Montgomery reduction: one conditional subtraction of m from a (WID+1)-bit value below 2m.
module mont_fred #(
    parameter int unsigned WID = 256
) (
    input  logic [WID:0]   x,
    input  logic [WID-1:0] m,
    output logic [WID-1:0] y
);

    logic ge_c;

    // When x >= m the true difference is below m, so the low WID bits are exact.
    assign ge_c = (x >= {1'b0, m});
    assign y    = ge_c ? (x[WID-1:0] - m) : x[WID-1:0];

endmodule

// File: rtl/mont_seq.sv
// Sequencer for the bit-serial radix-2 Montgomery core: latch, load, iterate WID cycles, reduce, return.
// Optional operand checking is enabled by defining MONT_SEQ_OPCHK_EN.
module mont_seq
    import mont_seq_pkg::*;
#(
    parameter int unsigned WID  = 256,
    parameter int unsigned CNTW = 9
) (
    input  logic           clk,
    input  logic           rst,
    mont_seq_if.slave      bus,
    output logic [WID-1:0] mp_a,
    output logic [WID-1:0] mp_b,
    output logic [WID-1:0] mp_m,
    output logic           mp_ldnew,
    input  logic [WID:0]   mp_r
);

    state_e          state;
    state_e          state_next;
    logic [CNTW-1:0] cnt;
    logic [WID-1:0]  bsel_c;
    logic [WID-1:0]  fred_c;
    logic [WID-1:0]  res_q;
    logic            err_q;
    logic            err_chk_c;
    logic            rdy_q;
    logic            vld_q;
    logic            accept_c;

    // Second multiplicand chosen by mode; reserved behaves as MUL.
    always_comb begin
        bsel_c = bus.b;
        case (mode_e'(bus.mode))
            MODE_TO_MONT:   bsel_c = bus.r2;
            MODE_FROM_MONT: bsel_c = WID'(1);
            default:        bsel_c = bus.b;
        endcase
    end

`ifdef MONT_SEQ_OPCHK_EN
    assign err_chk_c = ~bus.m[0] | (bus.a >= bus.m) |
                       ((mode_e'(bus.mode) != MODE_FROM_MONT) & (bsel_c >= bus.m));
`else
    assign err_chk_c = 1'b0;
`endif

    assign accept_c = (state == IDLE) & bus.start;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = err_chk_c ? DONE : LOAD;
            LOAD:    state_next = RUN;
            RUN:     if (cnt == CNTW'(WID - 1)) state_next = REDUCE;
            REDUCE:  state_next = DONE;
            // Ack only counts once the result is actually presented.
            DONE:    if (bus.res_ack & vld_q) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Operand latches, iteration counter, result capture and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mp_a     <= '0;
            mp_b     <= '0;
            mp_m     <= '0;
            mp_ldnew <= 1'b0;
            cnt      <= '0;
            res_q    <= '0;
            err_q    <= 1'b0;
            rdy_q    <= 1'b1;
            vld_q    <= 1'b0;
        end else begin
            rdy_q    <= (state_next == IDLE);
            mp_ldnew <= (state_next == LOAD);
            // An operand error enters DONE straight from IDLE; valid follows one cycle later.
            vld_q    <= (state_next == DONE) & (state != IDLE);
            if (accept_c) begin
                mp_a  <= bus.a;
                mp_b  <= bsel_c;
                mp_m  <= bus.m;
                res_q <= '0;
                err_q <= err_chk_c;
            end
            case (state)
                LOAD:    cnt   <= '0;
                RUN:     cnt   <= cnt + CNTW'(1);
                REDUCE:  res_q <= fred_c;
                default: ;
            endcase
        end
    end

    mont_fred #(.WID(WID)) u_fred (
        .x (mp_r),
        .m (mp_m),
        .y (fred_c)
    );

    assign bus.ready   = rdy_q;
    assign bus.res_vld = vld_q;
    assign bus.res     = res_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_mont_seq.sv
// Bench for mont_seq at WID=8 with a behavioural bit-serial Montgomery core attached.
module tb_mont_seq;

    localparam int unsigned WID  = 8;
    localparam int unsigned CNTW = 4;
    localparam logic [7:0]  M0   = 8'hF1;
    localparam logic [7:0]  R2   = 8'hE1;

    typedef struct {
        logic [7:0] res;
        logic       err;
        int         lat;
    } exp_t;

    logic           clk;
    logic           rst;
    logic [WID-1:0] mp_a;
    logic [WID-1:0] mp_b;
    logic [WID-1:0] mp_m;
    logic           mp_ldnew;
    logic [WID:0]   mp_r;

    logic [WID:0]   acc;
    logic [WID-1:0] ash;
    int             iter;
    logic [WID:0]   last_r;
    int             ldn_cnt;
    int             n_chk;
    int             n_err;
    exp_t           sbq[$];

    mont_seq_if #(.WID(WID)) bus ();

    mont_seq #(.WID(WID), .CNTW(CNTW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .mp_a     (mp_a),
        .mp_b     (mp_b),
        .mp_m     (mp_m),
        .mp_ldnew (mp_ldnew),
        .mp_r     (mp_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WID:0] core_step(logic [WID:0] r, logic abit,
                                               logic [WID-1:0] bb, logic [WID-1:0] mm);
        logic [WID+1:0] s;
        s = {1'b0, r} + (abit ? {2'b00, bb} : '0);
        if (s[0]) s = s + {2'b00, mm};
        return s[WID+1:1];
    endfunction

    function automatic logic [WID:0] core_raw(logic [WID-1:0] aa, logic [WID-1:0] bb,
                                              logic [WID-1:0] mm);
        logic [WID:0] r;
        r = '0;
        for (int i = 0; i < int'(WID); i++) r = core_step(r, aa[i], bb, mm);
        return r;
    endfunction

    // Behavioural core: ldnew loads a and clears r, otherwise one iteration per edge.
    always @(posedge clk) begin
        if (mp_ldnew) begin
            ash  <= mp_a;
            acc  <= '0;
            iter <= 0;
        end else begin
            acc  <= core_step(acc, ash[0], mp_b, mp_m);
            ash  <= ash >> 1;
            iter <= iter + 1;
        end
    end
    assign mp_r = acc;

    always @(negedge clk) begin
        if (iter == int'(WID)) last_r = acc;
        if (mp_ldnew) ldn_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] bop(logic [1:0] md, logic [7:0] ib);
        case (md)
            2'd1:    return R2;
            2'd2:    return 8'd1;
            default: return ib;
        endcase
    endfunction

    // Reference a*b*R^-1 mod m from plain integer arithmetic, R = 256.
    function automatic logic [7:0] exp_mont(logic [7:0] ia, logic [7:0] ib, logic [7:0] im);
        int unsigned p;
        int unsigned rinv;
        p    = (32'(ia) * 32'(ib)) % 32'(im);
        rinv = 0;
        for (int unsigned x = 1; x < 32'(im); x++)
            if (((x * 256) % 32'(im)) == 1) rinv = x;
        return 8'((p * rinv) % 32'(im));
    endfunction

    function automatic exp_t make_exp(logic [1:0] md, logic [7:0] ia, logic [7:0] ib,
                                      logic [7:0] im);
        exp_t e;
        logic bad;
        bad = 1'b0;
`ifdef MONT_SEQ_OPCHK_EN
        bad = ~im[0] | (ia >= im) | ((md != 2'd2) & (bop(md, ib) >= im));
`endif
        e.err = bad;
        e.res = bad ? 8'h00 : exp_mont(ia, bop(md, ib), im);
        e.lat = bad ? 1 : int'(WID) + 2;
        return e;
    endfunction

    task automatic drive(input logic [1:0] md, input logic [7:0] ia, input logic [7:0] ib,
                         input logic [7:0] im);
        @(negedge clk);
        chk("ready_before_start", 32'(bus.ready), 32'd1);
        bus.mode  = md;
        bus.a     = ia;
        bus.b     = ib;
        bus.r2    = R2;
        bus.m     = im;
        bus.start = 1'b1;
        ldn_cnt   = 0;
        sbq.push_back(make_exp(md, ia, ib, im));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic collect(input string tag);
        int   lat;
        exp_t e;
        lat = 0;
        while (!bus.res_vld && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        e = sbq.pop_front();
        chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
        chk({tag, "_res"}, 32'(bus.res), 32'(e.res));
        chk({tag, "_err"}, 32'(bus.err), 32'(e.err));
        if (!e.err) chk({tag, "_ldnew_cycles"}, 32'(ldn_cnt), 32'd1);
    endtask

    task automatic do_ack();
        @(negedge clk);
        bus.res_ack = 1'b1;
        @(negedge clk);
        bus.res_ack = 1'b0;
        chk("ack_back_to_idle", 32'({bus.ready, bus.res_vld}), 32'b10);
    endtask

    logic [7:0] pa, pb;
    bit         found;

    initial begin
        n_chk = 0; n_err = 0; ldn_cnt = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.res_ack = 1'b0; bus.mode = 2'd0;
        bus.a = '0; bus.b = '0; bus.r2 = R2; bus.m = M0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_vld", 32'(bus.res_vld), 32'd0);
        chk("rst_ldnew", 32'(mp_ldnew), 32'd0);
        chk("rst_res", 32'(bus.res), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        rst = 1'b0;

        drive(2'd1, 8'h03, 8'h00, M0);  collect("to_mont");
        chk("to_mont_const", 32'(bus.res), 32'h2D);
        do_ack();
        drive(2'd2, 8'h2D, 8'h00, M0);  collect("from_mont");
        chk("from_mont_const", 32'(bus.res), 32'h03);
        do_ack();
        drive(2'd0, 8'h2D, 8'h2D, M0);  collect("mul_2d");
        chk("mul_2d_const", 32'(bus.res), 32'h87);
        do_ack();
        drive(2'd0, 8'hF0, 8'hF0, M0);  collect("mul_f0");
        chk("mul_f0_const", 32'(bus.res), 32'hE1);
        do_ack();
        drive(2'd3, 8'h2D, 8'h2D, M0);  collect("rsvd_as_mul");
        do_ack();

        // Operand pair whose raw core output needs the final subtraction.
        found = 0; pa = 0; pb = 0;
        for (int i = int'(M0) - 1; i > 0 && !found; i--)
            for (int j = int'(M0) - 1; j > 0 && !found; j--)
                if (core_raw(8'(i), 8'(j), M0) >= {1'b0, M0}) begin
                    found = 1; pa = 8'(i); pb = 8'(j);
                end
        chk("sub_pair_found", 32'(found), 32'd1);
        drive(2'd0, pa, pb, M0);  collect("sub_pair");
        chk("sub_raw_ge_m", 32'(last_r >= {1'b0, M0}), 32'd1);
        do_ack();

        // Result held without ack; a start during DONE is ignored.
        drive(2'd0, 8'h2D, 8'h2D, M0);  collect("hold");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 2) begin bus.start = 1'b1; bus.a = 8'h11; end
            if (i == 3) bus.start = 1'b0;
            chk("hold_vld", 32'(bus.res_vld), 32'd1);
            chk("hold_res", 32'(bus.res), 32'h87);
        end
        @(negedge clk);
        bus.res_ack = 1'b1; bus.start = 1'b1; bus.a = 8'h11;
        @(negedge clk);
        bus.res_ack = 1'b0; bus.start = 1'b0;
        chk("ack_start_idle", 32'({bus.ready, bus.res_vld}), 32'b10);
        repeat (3) @(negedge clk);
        chk("start_with_ack_ignored", 32'({bus.ready, mp_ldnew}), 32'b10);
        drive(2'd1, 8'h03, 8'h00, M0);  collect("after_hold");
        do_ack();

        // Asynchronous reset in the middle of RUN.
        drive(2'd1, 8'h05, 8'h00, M0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_ready", 32'(bus.ready), 32'd1);
        chk("midrst_vld", 32'(bus.res_vld), 32'd0);
        chk("midrst_ldnew", 32'(mp_ldnew), 32'd0);
        chk("midrst_res", 32'(bus.res), 32'd0);
        void'(sbq.pop_front());
        @(negedge clk);
        rst = 1'b0;
        drive(2'd1, 8'h03, 8'h00, M0);  collect("post_rst");
        chk("post_rst_const", 32'(bus.res), 32'h2D);
        do_ack();

`ifdef MONT_SEQ_OPCHK_EN
        drive(2'd0, 8'h03, 8'h03, 8'hF0);  collect("chk_even_m");
        do_ack();
        drive(2'd0, 8'hF5, 8'h03, M0);     collect("chk_a_ge_m");
        do_ack();
        drive(2'd2, 8'h03, 8'hFF, M0);     collect("chk_from_ignores_b");
        do_ack();
`endif

        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
